// File: rtl/evm_pkg.sv
// Shared EVM definitions: session state encoding, voter ID width and
// candidate one-hot codes used by the session controller and its registry.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REJECT = 2'd2
    } session_state_e;

    localparam int ID_W = 5;

    localparam logic [2:0] CAND1 = 3'b001;
    localparam logic [2:0] CAND2 = 3'b010;
    localparam logic [2:0] CAND3 = 3'b100;

    // A selection counts only when exactly one candidate button fired.
    function automatic logic is_single_cand(input logic [2:0] buttons);
        logic ok;
        case (buttons)
            CAND1, CAND2, CAND3: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/voter_session_ctrl_if.sv
// Handshake/status bundle between the EVM front panel and the voter session
// controller; the top level drives it as master, the controller is the slave.
interface voter_session_if;

    logic                       mode;
    // "checker" is a reserved SystemVerilog keyword, hence the _pulse suffix.
    logic                       checker_pulse;
    logic [evm_pkg::ID_W-1:0]   serial;
    logic                       button1;
    logic                       button2;
    logic                       button3;
    logic [2:0]                 vote_valid;
    logic                       green_led;
    logic                       red_led;
    logic [5:0]                 voters_served;

    modport master (
        output mode, checker_pulse, serial, button1, button2, button3,
        input  vote_valid, green_led, red_led, voters_served
    );

    modport slave (
        input  mode, checker_pulse, serial, button1, button2, button3,
        output vote_valid, green_led, red_led, voters_served
    );

endinterface

// File: rtl/voter_registry.sv
// Used-ID bitmap: combinational lookup, registered set, cleared only by reset.
module voter_registry
    import evm_pkg::*;
#(
    parameter int NUM_IDS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [ID_W-1:0] lookup_id,
    output logic            used,
    input  logic            set_en,
    input  logic [ID_W-1:0] set_id
);

    logic [NUM_IDS-1:0] used_r;

    assign used = used_r[lookup_id];

    // Bitmap storage; a bit once set stays set until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            used_r <= '0;
        end else if (set_en) begin
            used_r[set_id] <= 1'b1;
        end else begin
            used_r <= used_r;
        end
    end

endmodule

// File: rtl/voter_session_ctrl.sv
// Per-voter session controller: authenticates an ID against the registry,
// arms the ballot for one selection, then emits a single one-hot vote pulse.
module voter_session_ctrl
    import evm_pkg::*;
#(
    parameter int NUM_IDS     = 32,
    parameter int ARM_TIMEOUT = 1000,
    parameter int REJECT_HOLD = 100
) (
    input  logic            clock,
    input  logic            reset,
    voter_session_if.slave  bus
);

    localparam int CNT_MAX = (ARM_TIMEOUT > REJECT_HOLD) ? ARM_TIMEOUT : REJECT_HOLD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(REJECT_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [5:0]       SERVED_MAX = 6'(NUM_IDS);
    localparam logic [5:0]       SERVED_ONE = 6'd1;

    session_state_e   state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [ID_W-1:0]  id_r, id_next_s;

    logic [2:0] buttons_s;
    logic       sel_ok_s;
    logic       id_used_s;
    logic       vote_fire_s;

    logic [2:0] vote_next_s, vote_valid_r;
    logic       green_next_s, green_r;
    logic       red_next_s, red_r;
    logic [5:0] served_next_s, served_r;

    assign buttons_s = {bus.button3, bus.button2, bus.button1};
    assign sel_ok_s  = is_single_cand(buttons_s);

    voter_registry #(
        .NUM_IDS (NUM_IDS)
    ) u_registry (
        .clock     (clock),
        .reset     (reset),
        .lookup_id (bus.serial),
        .used      (id_used_s),
        .set_en    (vote_fire_s),
        .set_id    (id_r)
    );

    // State, shared countdown and latched voter ID.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            id_r    <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            id_r    <= id_next_s;
        end
    end

    // Next-state logic; mode=1 overrides everything and closes the session.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        id_next_s    = id_r;
        if (bus.mode) begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.checker_pulse) begin
                        id_next_s = bus.serial;
                        if (id_used_s) begin
                            state_next_s = REJECT;
                            cnt_next_s   = HOLD_LOAD;
                        end else begin
                            state_next_s = ARMED;
                            cnt_next_s   = ARM_LOAD;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                // A valid selection beats a timeout expiring in the same cycle.
                ARMED: begin
                    if (sel_ok_s || (cnt_r == '0)) begin
                        state_next_s = IDLE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s   = cnt_r - CNT_ONE;
                    end
                end
                REJECT: begin
                    if (cnt_r == '0) begin
                        state_next_s = IDLE;
                    end else begin
                        cnt_next_s   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    // Output decode, computed one cycle ahead so every output is a flop.
    always_comb begin
        vote_fire_s  = (!bus.mode) && (state_r == ARMED) && sel_ok_s;
        green_next_s = (state_next_s == ARMED);
        red_next_s   = (state_next_s == REJECT);
        if (vote_fire_s) begin
            vote_next_s = buttons_s;
        end else begin
            vote_next_s = 3'b000;
        end
        if (vote_fire_s && (served_r != SERVED_MAX)) begin
            served_next_s = served_r + SERVED_ONE;
        end else begin
            served_next_s = served_r;
        end
    end

    // Registered outputs; cleared asynchronously so reset drops them at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vote_valid_r <= 3'b000;
            green_r      <= 1'b0;
            red_r        <= 1'b0;
            served_r     <= 6'd0;
        end else begin
            vote_valid_r <= vote_next_s;
            green_r      <= green_next_s;
            red_r        <= red_next_s;
            served_r     <= served_next_s;
        end
    end

    assign bus.vote_valid    = vote_valid_r;
    assign bus.green_led     = green_r;
    assign bus.red_led       = red_r;
    assign bus.voters_served = served_r;

endmodule
